// File: rtl/wirelog_pkg.sv
// ---------------------------------------------------------------------------
// wirelog_pkg
//   Definitions shared by the gate output pulser and its per-channel slice:
//   the default pending-counter width, the counter type at that width, the
//   counter update actions, and a helper that gives the saturation value
//   for any counter width.
// ---------------------------------------------------------------------------
package wirelog_pkg;

  // Default width of a per-channel pending-pulse counter.
  localparam int unsigned CNT_W_DEFAULT = 3;

  // Pending counter at the default width.
  typedef logic [CNT_W_DEFAULT-1:0] pending_t;

  // What a channel's pending counter does in a given cycle.
  //   CNT_HOLD : no event, or an edge and a release cancelling each other
  //   CNT_INC  : a new edge with no release
  //   CNT_DEC  : a release with no new edge
  //   CNT_SAT  : a new edge while already at max; the edge is dropped
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2,
    CNT_SAT  = 2'd3
  } cnt_action_e;

  // Largest pending count a counter of the given width can hold.
  function automatic int unsigned pending_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/gate_output_pulser_channel.sv
// ---------------------------------------------------------------------------
// gate_pulse_channel
//   One channel of the gate output pulser. Every transition of the gate
//   output level is counted in a saturating pending counter. One pending
//   transition is released as a single-cycle pulse on each step strobe.
//
// Ports
//   clk           in   rising-edge clock
//   logic_reset_n in   asynchronous active-low reset
//   level         in   gate output level for this channel
//   primed        in   high once the level history is valid (edges count)
//   step          in   wire-update strobe; releases one pending pulse
//   pulse         out  registered one-cycle activation pulse
//   overflow      out  sticky flag: an edge was dropped at saturation
//   pending_live  out  next-state pending count is non-zero (feeds busy)
// ---------------------------------------------------------------------------
module gate_pulse_channel
  import wirelog_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic logic_reset_n,
  input  logic level,
  input  logic primed,
  input  logic step,
  output logic pulse,
  output logic overflow,
  output logic pending_live
);

  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(pending_max(CNT_W));

  logic             prev;
  logic [CNT_W-1:0] pending;
  logic [CNT_W-1:0] pending_next;
  logic             edge_seen;
  logic             release_now;
  logic             overflow_next;
  cnt_action_e      action;

  // Decide this cycle's counter action. The release is judged against the
  // current count, so an edge arriving while nothing is pending must wait
  // for the following step. An edge and a release in the same cycle cancel
  // out, which is why a channel sitting at max never overflows then.
  always_comb begin
    edge_seen   = primed & (level ^ prev);
    release_now = step & (pending != '0);
    action      = CNT_HOLD;
    if (edge_seen && !release_now) begin
      action = (pending == PEND_MAX) ? CNT_SAT : CNT_INC;
    end else if (release_now && !edge_seen) begin
      action = CNT_DEC;
    end
  end

  // Apply the action to the counter and the sticky overflow flag.
  always_comb begin
    pending_next  = pending;
    overflow_next = overflow;
    case (action)
      CNT_INC: pending_next  = pending + CNT_W'(1);
      CNT_DEC: pending_next  = pending - CNT_W'(1);
      CNT_SAT: overflow_next = 1'b1;
      default: pending_next  = pending;
    endcase
    pending_live = (pending_next != '0);
  end

  // Channel state. The level history is refreshed every cycle, including
  // the priming cycle, so the first sampled level never counts as an edge.
  always_ff @(posedge clk or negedge logic_reset_n) begin
    if (!logic_reset_n) begin
      prev     <= 1'b0;
      pending  <= '0;
      pulse    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      prev     <= level;
      pending  <= pending_next;
      pulse    <= release_now;
      overflow <= overflow_next;
    end
  end

endmodule

// File: rtl/gate_output_pulser.sv
// ---------------------------------------------------------------------------
// gate_output_pulser
//   Turns the steady output levels of a multi-output logic gate into
//   single-cycle wire activation pulses, one per level transition. Bursts
//   of transitions are queued per channel and drained one per step strobe.
//
// Ports
//   clk           in   rising-edge clock
//   logic_reset_n in   asynchronous active-low reset
//   in            in   [OUTPUT_COUNT] gate output levels
//   step          in   wire-update strobe
//   pulse         out  [OUTPUT_COUNT] registered one-cycle pulses
//   busy          out  registered: some channel has pulses pending
//   overflow      out  [OUTPUT_COUNT] sticky per-channel dropped-edge flag
// ---------------------------------------------------------------------------
module gate_output_pulser
  import wirelog_pkg::*;
#(
  parameter int unsigned OUTPUT_COUNT = 2,
  parameter int unsigned CNT_W        = CNT_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    logic_reset_n,
  input  logic [OUTPUT_COUNT-1:0] in,
  input  logic                    step,
  output logic [OUTPUT_COUNT-1:0] pulse,
  output logic                    busy,
  output logic [OUTPUT_COUNT-1:0] overflow
);

  logic                    primed;
  logic [OUTPUT_COUNT-1:0] pending_live;

  // The first clock after reset only captures the input levels; edges are
  // counted from the second clock on, so inputs that are already high when
  // reset releases never generate a pulse.
  always_ff @(posedge clk or negedge logic_reset_n) begin
    if (!logic_reset_n) begin
      primed <= 1'b0;
    end else begin
      primed <= 1'b1;
    end
  end

  for (genvar g = 0; g < OUTPUT_COUNT; g++) begin : g_channel
    gate_pulse_channel #(
      .CNT_W (CNT_W)
    ) u_channel (
      .clk           (clk),
      .logic_reset_n (logic_reset_n),
      .level         (in[g]),
      .primed        (primed),
      .step          (step),
      .pulse         (pulse[g]),
      .overflow      (overflow[g]),
      .pending_live  (pending_live[g])
    );
  end

  // Busy is registered from the channels' next-state counts, so it drops
  // in the same cycle as the final pulse of the last non-empty channel.
  always_ff @(posedge clk or negedge logic_reset_n) begin
    if (!logic_reset_n) begin
      busy <= 1'b0;
    end else begin
      busy <= |pending_live;
    end
  end

endmodule
